// File: rtl/ttc_trigger_receiver_mc_if.sv
// TTC Trigger FIFO write handshake: the receiver is master, the FIFO is slave.
interface ttc_trigger_receiver_mc_if;
  logic         fifo_ready;
  logic         fifo_valid;
  logic [127:0] fifo_data;

  modport master (input fifo_ready, output fifo_valid, output fifo_data);
  modport slave  (output fifo_ready, input fifo_valid, input fifo_data);
endinterface

// File: rtl/ttc_trigger_receiver_mc.sv
// Multi-channel TTC trigger receiver: numbering, timestamping, blocking, DDR3 occupancy gating.
// Optional recoverable ERROR state enabled by defining ERROR_RECOVERY_EN.
module ttc_trigger_receiver_mc #(
  parameter int unsigned NUM_CHAN    = 5,
  parameter int unsigned TRIG_NUM_W  = 24,
  parameter int unsigned TS_W        = 44,
  parameter int unsigned OCC_W       = 24,
  parameter int unsigned DDR3_BURSTS = 8388608
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         reset_trig_num,
  input  logic                         reset_trig_timestamp,
  input  logic                         clear_error,
  input  logic                         trigger,
  input  logic [1:0]                   trig_type,
  input  logic [3:0]                   trig_settings,
  input  logic [NUM_CHAN-1:0]          chan_en,
  input  logic [OCC_W-1:0]             thres_ddr3_overflow,
  input  logic [NUM_CHAN*23-1:0]       burst_count,
  input  logic [NUM_CHAN*12-1:0]       wfm_count,
  input  logic                         readout_done,
  input  logic [OCC_W-1:0]             readout_size,
  input  logic                         acq_ready,
  output logic                         acq_trigger,
  output logic [1:0]                   acq_trig_type,
  output logic [TRIG_NUM_W-1:0]        acq_trig_num,
  ttc_trigger_receiver_mc_if.master    fifo,
  output logic [4:0]                   state,
  output logic [TRIG_NUM_W-1:0]        trig_num,
  output logic [TS_W-1:0]              trig_timestamp,
  output logic [NUM_CHAN*OCC_W-1:0]    stored_bursts,
  output logic [31:0]                  ddr3_overflow_count,
  output logic [31:0]                  missed_trig_count,
  output logic [NUM_CHAN-1:0]          ddr3_overflow_warning,
  output logic                         error_trig_rate
);

`ifdef ERROR_RECOVERY_EN
  localparam bit RECOVERY = 1'b1;
`else
  localparam bit RECOVERY = 1'b0;
`endif

  localparam int unsigned PAD_W = 128 - (3 + 2*TRIG_NUM_W + TS_W);
  localparam logic [36:0] CAP = 37'(DDR3_BURSTS);
  localparam logic [TRIG_NUM_W-1:0] NUM_ONE = TRIG_NUM_W'(1);
  localparam logic [TS_W-1:0] TS_ONE = TS_W'(1);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_SEND  = 5'b00010,
    S_STORE = 5'b00100,
    S_DRAIN = 5'b01000,
    S_ERROR = 5'b10000
  } state_e;

  state_e                  state_q;
  logic [TS_W-1:0]         ts_cnt_q, trig_timestamp_q, pend_ts_q;
  logic [TRIG_NUM_W-1:0]   trig_num_q, acq_trig_num_q, acq_event_cnt_q, pend_num_q;
  logic [1:0]              acq_trig_type_q, pend_type_q;
  logic                    pend_valid_q;
  logic                    fifo_valid_q;
  logic [127:0]            fifo_data_q;
  logic [31:0]             ovf_cnt_q, missed_cnt_q;
  logic [OCC_W-1:0]        occ_q [NUM_CHAN];
  logic [OCC_W-1:0]        occ_d [NUM_CHAN];

  logic [35:0]             acq_size [NUM_CHAN];
  logic [36:0]             occ_sum  [NUM_CHAN];
  logic [36:0]             occ_sub  [NUM_CHAN];
  logic [NUM_CHAN-1:0]     chan_full;
  logic                    blocked, ddr3_full, pend_take, pend_miss;

  always_comb begin
    for (int unsigned c = 0; c < NUM_CHAN; c++) begin
      acq_size[c]  = (36'(burst_count[c*23 +: 23]) + 36'd1) * 36'(wfm_count[c*12 +: 12]) + 36'd2;
      chan_full[c] = chan_en[c] && (37'(acq_size[c]) > CAP - 37'(occ_q[c]));
    end
  end

  assign blocked   = trig_settings[acq_trig_type_q];
  assign ddr3_full = |chan_full;
  // Decided combinationally in SEND_TRIGGER so the pulse lands one cycle after the trigger.
  assign acq_trigger = (state_q == S_SEND) && acq_ready && !blocked && !ddr3_full;

  // A fill and a readout in the same cycle are netted before clamping/saturating.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CHAN; c++) begin
      occ_sum[c] = 37'(occ_q[c]) + ((acq_trigger && chan_en[c]) ? 37'(acq_size[c]) : 37'd0);
      occ_sub[c] = (readout_done && chan_en[c]) ? 37'(readout_size) : 37'd0;
      if (occ_sum[c] <= occ_sub[c])
        occ_d[c] = '0;
      else if (occ_sum[c] - occ_sub[c] > CAP)
        occ_d[c] = OCC_W'(DDR3_BURSTS);
      else
        occ_d[c] = OCC_W'(occ_sum[c] - occ_sub[c]);
    end
  end

  always_comb begin
    stored_bursts         = '0;
    ddr3_overflow_warning = '0;
    for (int unsigned c = 0; c < NUM_CHAN; c++) begin
      stored_bursts[c*OCC_W +: OCC_W] = occ_q[c];
      ddr3_overflow_warning[c]        = occ_q[c] > thres_ddr3_overflow;
    end
  end

  // DRAIN_PENDING frees the buffer in the same cycle, so a new trigger can refill it there.
  assign pend_take = trigger && ((state_q == S_DRAIN) ||
                     (((state_q == S_SEND) || (state_q == S_STORE)) && !pend_valid_q));
  assign pend_miss = trigger && pend_valid_q && ((state_q == S_SEND) || (state_q == S_STORE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      ts_cnt_q         <= '0;
      trig_timestamp_q <= '0;
      pend_ts_q        <= '0;
      trig_num_q       <= NUM_ONE;
      acq_trig_num_q   <= NUM_ONE;
      acq_event_cnt_q  <= NUM_ONE;
      pend_num_q       <= '0;
      acq_trig_type_q  <= '0;
      pend_type_q      <= '0;
      pend_valid_q     <= 1'b0;
      fifo_valid_q     <= 1'b0;
      fifo_data_q      <= '0;
      ovf_cnt_q        <= '0;
      missed_cnt_q     <= '0;
      for (int unsigned c = 0; c < NUM_CHAN; c++) occ_q[c] <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_ONE;
      for (int unsigned c = 0; c < NUM_CHAN; c++) occ_q[c] <= occ_d[c];

      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            acq_trig_num_q   <= trig_num_q;
            acq_trig_type_q  <= trig_type;
            trig_num_q       <= trig_num_q + NUM_ONE;
            trig_timestamp_q <= ts_cnt_q;
            state_q          <= S_SEND;
          end
        end
        S_SEND: begin
          if (!acq_ready) begin
            state_q <= S_ERROR;
          end else begin
            fifo_valid_q <= 1'b1;
            fifo_data_q  <= {{PAD_W{1'b0}}, ~acq_trigger, acq_trig_type_q, acq_event_cnt_q,
                             acq_trig_num_q, trig_timestamp_q};
            if (acq_trigger) acq_event_cnt_q <= acq_event_cnt_q + NUM_ONE;
            if (!blocked && ddr3_full) ovf_cnt_q <= ovf_cnt_q + 32'd1;
            state_q <= S_STORE;
          end
        end
        S_STORE: begin
          if (fifo.fifo_ready) begin
            fifo_valid_q <= 1'b0;
            state_q      <= (pend_valid_q || pend_take) ? S_DRAIN : S_IDLE;
          end
        end
        S_DRAIN: begin
          acq_trig_num_q   <= pend_num_q;
          acq_trig_type_q  <= pend_type_q;
          trig_timestamp_q <= pend_ts_q;
          pend_valid_q     <= 1'b0;
          state_q          <= S_SEND;
        end
        S_ERROR: begin
          if (trigger) missed_cnt_q <= missed_cnt_q + 32'd1;
          if (RECOVERY && clear_error) begin
            pend_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (pend_take) begin
        pend_valid_q <= 1'b1;
        pend_num_q   <= trig_num_q;
        pend_type_q  <= trig_type;
        pend_ts_q    <= ts_cnt_q;
        trig_num_q   <= trig_num_q + NUM_ONE;
      end
      if (pend_miss) begin
        missed_cnt_q <= missed_cnt_q + 32'd1;
        fifo_valid_q <= 1'b0;
        state_q      <= S_ERROR;
      end

      if (reset_trig_num) begin
        trig_num_q      <= NUM_ONE;
        acq_trig_num_q  <= NUM_ONE;
        acq_event_cnt_q <= NUM_ONE;
      end
      if (reset_trig_timestamp) begin
        trig_timestamp_q <= '0;
        ts_cnt_q         <= '0;
      end
    end
  end

  assign state               = state_q;
  assign trig_num            = trig_num_q;
  assign trig_timestamp      = trig_timestamp_q;
  assign acq_trig_num        = acq_trig_num_q;
  assign acq_trig_type       = acq_trig_type_q;
  assign ddr3_overflow_count = ovf_cnt_q;
  assign missed_trig_count   = missed_cnt_q;
  assign error_trig_rate     = (state_q == S_ERROR);
  assign fifo.fifo_valid     = fifo_valid_q;
  assign fifo.fifo_data      = fifo_data_q;

endmodule

// File: doc/ttc_trigger_receiver_mc.md
# ttc_trigger_receiver_mc

Parametrised multi-channel TTC trigger receiver, running on the 40 MHz TTC clock between the TTC decoder and the channel acquisition controllers. It numbers and timestamps each trigger and gates it against per-type blocking and per-channel DDR3 occupancy. Accepted triggers go to the channels; every trigger, accepted or refused, produces one word in the TTC Trigger FIFO. It adds a one-deep pending-trigger buffer, concurrent fill/drain occupancy accounting and an optional recoverable error state.

## Interface
- NUM_CHAN, 5: number of acquisition channels (1..8)
- TRIG_NUM_W, 24: trigger number / event count width
- TS_W, 44: timestamp width
- OCC_W, 24: per-channel occupancy width (holds DDR3_BURSTS)
- DDR3_BURSTS, 8388608: per-channel DDR3 capacity in bursts
---
- clk  in  1  40 MHz TTC clock
- reset_n  in  1  asynchronous, active-low reset
- reset_trig_num, reset_trig_timestamp  in  1 each  synchronous Channel B resets
- clear_error  in  1  leave ERROR (ERROR_RECOVERY_EN only)
- trigger  in  1  one-cycle trigger pulse
- trig_type  in  2  trigger type
- trig_settings  in  4  per-type block mask, 1 = block
- chan_en  in  NUM_CHAN  enabled channels
- thres_ddr3_overflow  in  OCC_W  warning threshold
- burst_count  in  NUM_CHAN*23  packed per-channel bursts per waveform minus 1
- wfm_count  in  NUM_CHAN*12  packed per-channel waveforms per fill
- readout_done  in  1  one-cycle pulse, a readout has finished
- readout_size  in  OCC_W  bursts freed by that readout
- acq_ready  in  1  channels are idle
- acq_trigger  out  1  one-cycle trigger to channels
- acq_trig_type  out  2; acq_trig_num  out  TRIG_NUM_W
- fifo_ready  in  1; fifo_valid  out  1; fifo_data  out  128
- state  out  5  one-hot FSM state
- trig_num  out  TRIG_NUM_W; trig_timestamp  out  TS_W
- stored_bursts  out  NUM_CHAN*OCC_W  packed occupancy
- ddr3_overflow_count, missed_trig_count  out  32 each
- ddr3_overflow_warning  out  NUM_CHAN  per channel, occupancy > threshold
- error_trig_rate  out  1  high while in ERROR

## Operation
- States: IDLE, SEND_TRIGGER, STORE_TRIG_INFO, DRAIN_PENDING, ERROR.
- Reset values: state = IDLE; trig_num, acq_trig_num, acq_event_cnt = 1; all timestamps = 0; stored_bursts = 0; counters = 0; acq_trigger, fifo_valid = 0; fifo_data = 0; acq_trig_type = 0.
- IDLE with trigger: latch acq_trig_num = trig_num and type; trig_num += 1; trig_timestamp = free-running counter. Go to SEND_TRIGGER.
- SEND_TRIGGER decision, in priority order:
  - !acq_ready: go to ERROR.
  - trig_settings[type] = 1: empty event.
  - DDR3 full on any enabled channel (DDR3_BURSTS − stored < acq_size): ddr3_overflow_count += 1, empty event.
  - Otherwise: acq_trigger pulses, acq_event_cnt += 1, enabled channels add acq_size.
  - All non-error outcomes go to STORE_TRIG_INFO.
- acq_size = (burst_count+1)*wfm_count + 2, computed at 36 bits. Any value > DDR3_BURSTS counts as full.
- STORE_TRIG_INFO: fifo_valid = 1 and fifo_data stays stable until fifo_ready. On the transfer, go to DRAIN_PENDING if a trigger is pending, otherwise IDLE.
- fifo_data = {zero pad, empty_event, acq_trig_type, acq_event_cnt, acq_trig_num, trig_timestamp}, LSB-aligned. Defaults give 33 zero bits.
- Pending buffer: a trigger arriving in SEND_TRIGGER or STORE_TRIG_INFO stores its number, type and timestamp, and trig_num increments. DRAIN_PENDING loads the pending fields as current, then goes to SEND_TRIGGER.
- A trigger arriving while the buffer is full: missed_trig_count += 1, go to ERROR.
- A trigger arriving in ERROR: counted in missed_trig_count only.
- Occupancy: add and subtract in the same cycle when acq_trigger and readout_done coincide. Subtraction clamps at 0; addition saturates at DDR3_BURSTS.
- reset_trig_num sets trig_num, acq_trig_num and acq_event_cnt to 1 and wins over any increment in the same cycle. reset_trig_timestamp zeroes trig_timestamp and the counter.

## Timing
- Trigger at cycle N: state = SEND_TRIGGER at N+1; acq_trigger high at N+1 for 1 cycle; fifo_valid high from N+2.
- Trigger to FIFO word, with fifo_ready held high: 2 cycles.
- Back-to-back pending service adds 1 cycle through DRAIN_PENDING.
- The free-running timestamp counter wraps at 2^TS_W; trig_num wraps at 2^TRIG_NUM_W to 0.
- reset_n assertion mid-transfer drops fifo_valid immediately (asynchronous); the pending trigger is discarded.

## Configuration
- ERROR_RECOVERY_EN defined: clear_error in ERROR clears the pending buffer and returns to IDLE next cycle; counters are kept.
- ERROR_RECOVERY_EN undefined: ERROR is sticky until reset_n; clear_error is ignored.

## Test plan
- Single trigger, acq_ready = 1, chan_en = 5'b00001, burst_count = 0, wfm_count = 1 -> acq_trigger at N+1; stored_bursts[0] = 3; FIFO word has event_cnt 1, trig_num 1, empty 0.
- trig_settings = 4'b0010, trig_type = 1 -> no acq_trigger; FIFO word has empty = 1; acq_event_cnt unchanged.
- stored_bursts[0] = 8388606, acq_size = 3 -> ddr3_overflow_count = 1; empty event.
- acq_trigger and readout_done (size 3) coincide, occupancy 10, acq_size 3 -> occupancy 10.
- Three triggers 1 cycle apart, fifo_ready = 0 -> second is buffered; third gives ERROR and missed_trig_count = 1. With ERROR_RECOVERY_EN, clear_error -> IDLE.
- acq_ready = 0 on trigger -> error_trig_rate = 1 at N+2; no FIFO word.
